// File: rtl/pin_access_pkg.sv
// Shared encodings and default parameters for the PIN access arbiter slice.
package pin_access_pkg;

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_COLLECT = 4'b0010;
    localparam logic [3:0] ST_CHECK   = 4'b0100;
    localparam logic [3:0] ST_RESULT  = 4'b1000;

    typedef enum logic [3:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        CHECK   = ST_CHECK,
        RESULT  = ST_RESULT
    } state_t;

    localparam logic [15:0] DEF_CLAVE       = 16'h6969;
    localparam int          DEF_MAX_TRIES   = 3;
    localparam int          DEF_LOCK_CYCLES = 16;
    localparam int          DEF_TIMEOUT     = 8;

endpackage

// File: rtl/lockout_tracker.sv
// One keypad's consecutive-failure count and timed lockout.
module lockout_tracker
    import pin_access_pkg::*;
#(
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_fail,
    input  logic i_pass,
    output logic o_bloqueo
);

    logic [1:0] r_fails;
    logic [7:0] r_lock;
    logic       r_bloqueo;

    // Lock is loaded on the same edge that registers the deny pulse, so both rise together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fails   <= 2'd0;
            r_lock    <= 8'd0;
            r_bloqueo <= 1'b0;
        end else if (r_bloqueo) begin
            if (r_lock == 8'd1) begin
                r_bloqueo <= 1'b0;
                r_lock    <= 8'd0;
                r_fails   <= 2'd0;
            end else begin
                r_lock <= r_lock - 8'd1;
            end
        end else if (i_pass) begin
            r_fails <= 2'd0;
        end else if (i_fail) begin
            if (r_fails == 2'(MAX_TRIES - 1)) begin
                r_fails   <= 2'(MAX_TRIES);
                r_bloqueo <= 1'b1;
                r_lock    <= 8'(LOCK_CYCLES);
            end else begin
                r_fails <= r_fails + 2'd1;
            end
        end
    end

    assign o_bloqueo = r_bloqueo;

endmodule

// File: rtl/pin_access_arbiter.sv
// Round-robin shared PIN checker for two keypads: grant, collect 4 digits,
// compare against the stored key, pulse accept/deny and track lockouts.
module pin_access_arbiter
    import pin_access_pkg::*;
#(
    parameter logic [15:0] CLAVE       = DEF_CLAVE,
    parameter int          MAX_TRIES   = DEF_MAX_TRIES,
    parameter int          LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int          TIMEOUT     = DEF_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] SOLICITUD_ACCESO,
    input  logic [1:0] DIGITO_STB,
    input  logic [3:0] DIGITO0,
    input  logic [3:0] DIGITO1,
    output logic [1:0] GRANT,
    output logic [1:0] ACCESO_ACEPTADO,
    output logic [1:0] ACCESO_DENEGADO,
    output logic [1:0] BLOQUEO,
    output logic       BUSY
);

    state_t      r_state;
    logic        r_gsel;
    logic        r_last;
    logic [1:0]  r_grant;
    logic        r_busy;
    logic [1:0]  r_acc;
    logic [1:0]  r_den;
    logic [15:0] r_key;
    logic [1:0]  r_idx;
    logic [7:0]  r_tmo;

    logic [1:0]  w_bloqueo;
    logic [1:0]  w_elig;
    logic        w_pick;
    logic [1:0]  w_gmask;
    logic        w_stb_g;
    logic [3:0]  w_digit;
    logic        w_match;
    logic        w_timeout;
    logic [1:0]  w_pass;
    logic [1:0]  w_fail;

    always_comb begin
        w_elig    = SOLICITUD_ACCESO & ~w_bloqueo;
        // On a tie the keypad not served last wins.
        w_pick    = (w_elig == 2'b11) ? ~r_last : w_elig[1];
        w_gmask   = r_gsel ? 2'b10 : 2'b01;
        w_stb_g   = DIGITO_STB[r_gsel];
        w_digit   = r_gsel ? DIGITO1 : DIGITO0;
        w_match   = (r_key == CLAVE);
        w_timeout = (r_state == COLLECT) && !w_stb_g && (r_tmo == 8'(TIMEOUT - 1));
        w_pass    = 2'b00;
        w_fail    = 2'b00;
        if (r_state == CHECK) begin
            if (w_match) w_pass = w_gmask;
            else         w_fail = w_gmask;
        end else if (w_timeout) begin
            w_fail = w_gmask;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_gsel  <= 1'b0;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_acc   <= 2'b00;
            r_den   <= 2'b00;
            r_key   <= 16'h0000;
            r_idx   <= 2'd0;
            r_tmo   <= 8'd0;
        end else begin
            r_acc <= 2'b00;
            r_den <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_elig != 2'b00) begin
                        r_gsel  <= w_pick;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_idx   <= 2'd0;
                        r_tmo   <= 8'd0;
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_stb_g) begin
                        r_key <= {r_key[11:0], w_digit};
                        r_tmo <= 8'd0;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) r_state <= CHECK;
                    end else if (w_timeout) begin
                        r_den   <= w_fail;
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= RESULT;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                CHECK: begin
                    // Pulses are registered here so they are visible during RESULT.
                    r_acc   <= w_pass;
                    r_den   <= w_fail;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= RESULT;
                end
                RESULT: begin
                    r_last  <= r_gsel;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    lockout_tracker #(.MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)) u_lock0 (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_fail    (w_fail[0]),
        .i_pass    (w_pass[0]),
        .o_bloqueo (w_bloqueo[0])
    );

    lockout_tracker #(.MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)) u_lock1 (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_fail    (w_fail[1]),
        .i_pass    (w_pass[1]),
        .o_bloqueo (w_bloqueo[1])
    );

    assign GRANT           = r_grant;
    assign ACCESO_ACEPTADO = r_acc;
    assign ACCESO_DENEGADO = r_den;
    assign BLOQUEO         = w_bloqueo;
    assign BUSY            = r_busy;

endmodule
